// File: rtl/prio_encoder_4to2_hs.sv
// prio_encoder_4to2_hs: sequential 4-to-2 priority encoder with a valid/ready output.
// Request pulses are collected in a pending register. The highest-priority pending
// line is offered as a 2-bit code, and that line is cleared when the code is accepted.
// Requests that hit an already pending line are counted in a saturating drop counter.
module prio_encoder_4to2_hs #(
   parameter int unsigned HIGH_FIRST = 1,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req_in,
   output logic [1:0]       out_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       pending,
   output logic             busy,
   output logic [CNT_W-1:0] drop_cnt
);

   // The sum is 3 bits wider than the counter so that count + 4 never overflows before the clamp.
   localparam int unsigned SUM_W = CNT_W + 3;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t           r_state;

   logic             w_fire;
   logic [3:0]       w_srv;
   logic [3:0]       w_drop_vec;
   logic [2:0]       w_drop_num;
   logic [SUM_W-1:0] w_cnt_sum;
   logic [CNT_W-1:0] w_cnt_next;
   logic [3:0]       w_pend_next;
   logic [1:0]       w_enc;

   // Index of the highest-priority set bit; the later match in scan order wins.
   function automatic logic [1:0] enc(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      if (HIGH_FIRST != 0) begin
         for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
         end
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
         end
      end
      return idx;
   endfunction

   assign w_fire = out_valid & out_ready;

   // One-hot mask of the line whose code is accepted this cycle.
   always_comb begin
      w_srv = 4'b0000;
      if (w_fire) w_srv[out_code] = 1'b1;
   end

   // A request that hits a pending line not being served this cycle is lost.
   assign w_drop_vec = req_in & pending & ~w_srv;
   assign w_drop_num = 3'(w_drop_vec[0]) + 3'(w_drop_vec[1])
                     + 3'(w_drop_vec[2]) + 3'(w_drop_vec[3]);

   // The drop counter clamps at all-ones instead of wrapping.
   always_comb begin
      w_cnt_sum  = SUM_W'(drop_cnt) + SUM_W'(w_drop_num);
      w_cnt_next = drop_cnt;
      if (w_cnt_sum > CNT_MAX) w_cnt_next = {CNT_W{1'b1}};
      else                     w_cnt_next = w_cnt_sum[CNT_W-1:0];
   end

   // The served line clears, and a new pulse on that same line re-arms it.
   assign w_pend_next = (pending & ~w_srv) | req_in;

   // The encoder looks at registered pending only, so same-cycle requests wait a cycle.
   assign w_enc = enc(pending);

   // Pending, drop counter and grant FSM; the code is frozen for the whole of HOLD.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         pending   <= 4'b0000;
         out_code  <= 2'd0;
         out_valid <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         pending  <= w_pend_next;
         drop_cnt <= w_cnt_next;
         case (r_state)
            ST_IDLE: begin
               out_valid <= 1'b0;
               if (pending != 4'b0000) begin
                  out_code  <= w_enc;
                  out_valid <= 1'b1;
                  r_state   <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_fire) begin
                  out_valid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // Busy while there is work queued or a code is being offered.
   assign busy = (pending != 4'b0000) | out_valid;

endmodule

// File: tb/tb_prio_encoder_4to2_hs.sv
// Bench for prio_encoder_4to2_hs: two instances share the stimulus.
// Instance 0 uses HIGH_FIRST=1 and CNT_W=8. Instance 1 uses HIGH_FIRST=0 and CNT_W=2.
// Each instance is checked against its own cycle-level reference model.
module tb_prio_encoder_4to2_hs;

   logic       clk;
   logic       rst;
   logic [3:0] req_in;
   logic       out_ready;

   logic [1:0] d0_code, d1_code;
   logic       d0_valid, d1_valid;
   logic [3:0] d0_pend, d1_pend;
   logic       d0_busy, d1_busy;
   logic [7:0] d0_drop;
   logic [1:0] d1_drop;

   int n_total;
   int n_bad;

   // Reference model state, one entry per instance.
   bit [3:0] m_pend  [2];
   bit       m_valid [2];
   int       m_code  [2];
   int       m_drop  [2];
   int       m_max   [2];

   int q0 [$];
   int q1 [$];

   prio_encoder_4to2_hs #(.HIGH_FIRST(1), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst(rst), .req_in(req_in),
      .out_code(d0_code), .out_valid(d0_valid), .out_ready(out_ready),
      .pending(d0_pend), .busy(d0_busy), .drop_cnt(d0_drop)
   );

   prio_encoder_4to2_hs #(.HIGH_FIRST(0), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .req_in(req_in),
      .out_code(d1_code), .out_valid(d1_valid), .out_ready(out_ready),
      .pending(d1_pend), .busy(d1_busy), .drop_cnt(d1_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Highest-priority pending line for instance k.
   function automatic int pick(input int k, input bit [3:0] p);
      int order [4];
      if (k == 0) order = '{3, 2, 1, 0};
      else        order = '{0, 1, 2, 3};
      for (int j = 0; j < 4; j++) begin
         if (p[order[j]]) return order[j];
      end
      return -1;
   endfunction

   // Advance model k by one clock edge using the inputs currently applied.
   task automatic model_step(input int k);
      int  served;
      int  dropped;
      bit  fire;
      bit [3:0] np;
      if (rst) begin
         m_pend[k]  = 4'b0000;
         m_valid[k] = 1'b0;
         m_code[k]  = 0;
         m_drop[k]  = 0;
         return;
      end
      fire    = m_valid[k] && out_ready;
      served  = fire ? m_code[k] : -1;
      dropped = 0;
      for (int i = 0; i < 4; i++) begin
         if (req_in[i] && m_pend[k][i] && i != served) dropped++;
         np[i] = (m_pend[k][i] && i != served) || req_in[i];
      end
      m_drop[k] = (m_drop[k] + dropped > m_max[k]) ? m_max[k] : m_drop[k] + dropped;
      if (!m_valid[k]) begin
         if (m_pend[k] != 4'b0000) begin
            m_code[k]  = pick(k, m_pend[k]);
            m_valid[k] = 1'b1;
         end
      end else if (fire) begin
         m_valid[k] = 1'b0;
      end
      m_pend[k] = np;
   endtask

   task automatic compare_all();
      check("code0",  d0_code,  m_code[0]);
      check("valid0", d0_valid, m_valid[0]);
      check("pend0",  d0_pend,  m_pend[0]);
      check("busy0",  d0_busy,  (m_pend[0] != 0) || m_valid[0]);
      check("drop0",  d0_drop,  m_drop[0]);
      check("code1",  d1_code,  m_code[1]);
      check("valid1", d1_valid, m_valid[1]);
      check("pend1",  d1_pend,  m_pend[1]);
      check("busy1",  d1_busy,  (m_pend[1] != 0) || m_valid[1]);
      check("drop1",  d1_drop,  m_drop[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      compare_all();
   endtask

   // Run n cycles and log every code accepted by each instance.
   task automatic run_collect(input int n);
      q0.delete();
      q1.delete();
      for (int c = 0; c < n; c++) begin
         if (d0_valid && out_ready) q0.push_back(int'(d0_code));
         if (d1_valid && out_ready) q1.push_back(int'(d1_code));
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_in = 4'b0000;
      out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_total   = 0;
      n_bad     = 0;
      m_max[0]  = 255;
      m_max[1]  = 3;
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 0; m_valid[k] = 0; m_code[k] = 0; m_drop[k] = 0;
      end
      rst       = 1'b1;
      req_in    = 4'b1111;
      out_ready = 1'b0;
      @(negedge clk);

      // Reset holds everything clear even with all requests high.
      tick();
      tick();
      check("rst_pend",  d0_pend, 0);
      check("rst_valid", d0_valid, 0);
      check("rst_drop",  d0_drop, 0);
      check("rst_busy",  d0_busy, 0);
      rst = 1'b0;
      tick();
      check("rst_rel_pend", d0_pend, 4'b1111);
      do_reset();

      // A single request is granted after edge 2 and retired after edge 3.
      req_in = 4'b0100;
      out_ready = 1'b1;
      tick();
      req_in = 4'b0000;
      check("single_pend1",  d0_pend, 4'b0100);
      check("single_valid1", d0_valid, 0);
      tick();
      check("single_valid2", d0_valid, 1);
      check("single_code2",  d0_code, 2);
      tick();
      check("single_valid3", d0_valid, 0);
      check("single_pend3",  d0_pend, 0);
      do_reset();

      // Grant order for 1011 under both priority directions.
      req_in = 4'b1011;
      out_ready = 1'b1;
      tick();
      req_in = 4'b0000;
      run_collect(12);
      check("ord_n0", q0.size(), 3);
      check("ord_n1", q1.size(), 3);
      if (q0.size() == 3) begin
         check("ord0_a", q0[0], 3);
         check("ord0_b", q0[1], 1);
         check("ord0_c", q0[2], 0);
      end
      if (q1.size() == 3) begin
         check("ord1_a", q1[0], 0);
         check("ord1_b", q1[1], 1);
         check("ord1_c", q1[2], 3);
      end
      do_reset();

      // Backpressure: a higher-priority request must not disturb the offered code.
      req_in = 4'b0001;
      tick();
      req_in = 4'b0000;
      for (int c = 0; c < 5; c++) tick();
      req_in = 4'b1000;
      tick();
      req_in = 4'b0000;
      tick();
      check("bp_code",  d0_code, 0);
      check("bp_valid", d0_valid, 1);
      check("bp_pend",  d0_pend, 4'b1001);
      out_ready = 1'b1;
      run_collect(8);
      check("bp_n0", q0.size(), 2);
      if (q0.size() == 2) begin
         check("bp_first",  q0[0], 0);
         check("bp_second", q0[1], 3);
      end
      do_reset();

      // Drops onto pending lines, then a re-arm on the line being served.
      req_in = 4'b0110;
      tick();
      req_in = 4'b0000;
      tick();
      check("drop_code", d0_code, 2);
      req_in = 4'b0111;
      tick();
      check("drop_cnt2", d0_drop, 2);
      check("drop_pend", d0_pend, 4'b0111);
      req_in = 4'b0100;
      out_ready = 1'b1;
      tick();
      check("rearm_cnt",  d0_drop, 2);
      check("rearm_pend", d0_pend, 4'b0111);
      out_ready = 1'b0;
      req_in = 4'b0000;
      do_reset();

      // Five drops saturate the 2-bit counter, then reset clears a live grant.
      req_in = 4'b1111;
      tick();
      tick();
      req_in = 4'b0001;
      tick();
      req_in = 4'b0000;
      check("sat_drop1", d1_drop, 3);
      check("sat_drop0", d0_drop, 5);
      check("sat_valid", d0_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", d0_valid, 0);
      check("midrst_pend",  d0_pend, 0);
      check("midrst_drop",  d0_drop, 0);

      // Randomized traffic with random backpressure and occasional reset.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) req_in[i] = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      req_in = 4'b0000;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/prio_encoder_4to2_hs.md
Name: prio_encoder_4to2_hs

Overview:
- Sequential 4-to-2 priority encoder; the encode direction of the team's 2-to-4 decoder.
- Captures single-cycle request pulses on 4 lines into a pending register.
- Emits the 2-bit index of the highest-priority pending line over a valid/ready handshake, then clears that line.
- Sits between event sources (interrupt or request lines) and a consumer that drives the 2-to-4 decoder with the returned code.

Parameters:
- HIGH_FIRST, 1, priority order: 1 = bit 3 highest, bit 0 lowest; 0 = bit 0 highest, bit 3 lowest.
- CNT_W, 8, width of the saturating dropped-request counter.

Ports:
- clk  input  1  single clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  4  request pulses; any number of bits may be high in one cycle.
- out_code  output  2  encoded index of the granted line.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code.
- pending  output  4  registered pending-request vector.
- busy  output  1  high when pending != 0 or out_valid = 1.
- drop_cnt  output  CNT_W  saturating count of dropped requests.

Behaviour:
- Reset: rst is synchronous, active-high and sampled on the rising edge of clk. While rst is high at an edge, all of these are 0 after that edge: pending, out_code, out_valid, drop_cnt, state (IDLE). busy is 0 as a result. req_in is ignored in those cycles. Reset mid-handshake discards the offered code without a handshake.
- Handshake: fire = out_valid & out_ready. out_code is stable while out_valid=1 and fire=0. out_valid deasserts only after fire. out_ready may be high while out_valid=0; this has no effect.
- Served mask: srv = one-hot(out_code) when fire, else 0.
- Pending update every edge: pending <= (pending & ~srv) | req_in.
  - A req_in bit equal to the bit being served in the same cycle re-arms that bit. This is a new request, not a drop.
- Drop rule: drop_vec = req_in & pending & ~srv.
  - drop_cnt <= min(drop_cnt + popcount(drop_vec), 2^CNT_W - 1).
  - Increment per cycle is 0..4; the counter saturates and never wraps.
- FSM, 2 states:
  - IDLE: out_valid=0. If pending != 0, then at the next edge load out_code <= enc(pending), set out_valid <= 1, go to HOLD. If pending == 0, stay in IDLE.
  - HOLD: out_valid=1. On fire, go to IDLE with out_valid <= 0. Otherwise stay in HOLD with the code frozen.
- enc(): index of the highest-priority set bit per HIGH_FIRST.
  - enc() is evaluated on registered pending only. A req_in arriving in the same cycle is not visible to enc().
- Requests arriving during HOLD accumulate in pending. They never change the current out_code, even if higher priority.
- Latency:
  - req_in pulse at cycle 0 → pending set after edge 1 → out_valid high after edge 2.
  - After fire there is one mandatory IDLE bubble cycle. Maximum throughput is one grant per 2 cycles.
- All outputs are registered except busy. busy is combinational from registers only.

Test Plan:
- Reset: hold rst 2 cycles with req_in=4'b1111 → pending=0, out_valid=0, drop_cnt=0, busy=0. First edge after rst falls: pending=4'b1111 only if req_in is still high.
- Single request, HIGH_FIRST=1: pulse req_in=4'b0100 at cycle 0, out_ready=1.
  - → out_valid=1, out_code=2 after edge 2.
  - → pending=0 after edge 3; out_valid=0 after edge 3.
- Multi-request ordering, HIGH_FIRST=1: pulse req_in=4'b1011, out_ready=1 → grants in order 3, 1, 0, each separated by one idle cycle. Repeat with HIGH_FIRST=0 → grants in order 0, 1, 3.
- Backpressure: pending=4'b0001 granted (code 0), out_ready=0 for 5 cycles, then pulse req_in=4'b1000 → out_code stays 0 and out_valid stays 1. After out_ready=1: code 0 fires, then code 3.
- Drops and re-arm:
  - With pending=4'b0110 and no fire, pulse req_in=4'b0111 → drop_cnt += 2, pending=4'b0111.
  - Pulse req_in=4'b0100 in the same cycle that code 2 fires → drop_cnt unchanged, pending bit 2 stays set.
- Saturation and reset mid-operation:
  - CNT_W=2: cause 5 drops → drop_cnt=3.
  - Assert rst while out_valid=1 → next cycle out_valid=0, pending=0, drop_cnt=0.
